// File: rtl/conf_pkg.sv
// Shared configuration for the fall-in dispatch stage: bucket count, key width,
// bucket capacity and the types derived from them.
package conf_pkg;

  localparam int BUFFER_DEPTH = 4;
  localparam int DATA_WIDTH   = 16;
  localparam int BUCKET_CAP   = 16;

  localparam int PTR_WIDTH   = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int COUNT_WIDTH = $clog2(BUCKET_CAP + 1);

  typedef logic [PTR_WIDTH-1:0]   buffer_pointer_t;
  typedef logic [DATA_WIDTH-1:0]  data_t;
  typedef logic [COUNT_WIDTH-1:0] count_t;

  // Contents of the output register.
  typedef struct packed {
    data_t           data;
    buffer_pointer_t index;
    logic            miss;
  } result_t;

  // A bucket is live only when its bounds form a non-empty unsigned interval.
  function automatic logic range_enabled(input data_t lo, input data_t hi);
    return (lo <= hi);
  endfunction

endpackage

// File: rtl/range_compare.sv
// Parallel range check of one key against every bucket, producing the fall_in
// vector (enabled, inside [lo,hi] inclusive, and not full).
module range_compare
  import conf_pkg::*;
(
  input  data_t                      key,
  input  data_t [BUFFER_DEPTH-1:0]   lo,
  input  data_t [BUFFER_DEPTH-1:0]   hi,
  input  logic  [BUFFER_DEPTH-1:0]   enabled,
  input  logic  [BUFFER_DEPTH-1:0]   full,
  output logic  [BUFFER_DEPTH-1:0]   fall_in
);

  genvar gi;
  generate
    for (gi = 0; gi < BUFFER_DEPTH; gi++) begin : g_cmp
      logic above_lo;
      logic below_hi;

      assign above_lo    = (key >= lo[gi]);
      assign below_hi    = (key <= hi[gi]);
      assign fall_in[gi] = enabled[gi] & above_lo & below_hi & ~full[gi];
    end
  endgenerate

endmodule

// File: rtl/fall_in_dispatch.sv
// Registered dispatch stage: classifies each key into the lowest-indexed eligible
// bucket, tracks per-bucket occupancy and never routes a key to a full bucket.
module fall_in_dispatch
  import conf_pkg::*;
#(
  parameter int CAP = BUCKET_CAP
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  buffer_pointer_t         cfg_idx,
  input  data_t                   cfg_lo,
  input  data_t                   cfg_hi,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  data_t                   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output data_t                   out_data,
  output buffer_pointer_t         out_index,
  output logic                    out_miss,
  input  logic                    drain_valid,
  input  buffer_pointer_t         drain_idx,
  output logic [BUFFER_DEPTH-1:0] bucket_full
);

  localparam int CNT_W = $clog2(CAP + 1);
  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAP);

  data_t [BUFFER_DEPTH-1:0] lo_arr;
  data_t [BUFFER_DEPTH-1:0] hi_arr;
  logic  [BUFFER_DEPTH-1:0] enabled;
  logic  [BUFFER_DEPTH-1:0] full;
  logic  [BUFFER_DEPTH-1:0] fall_in;

  buffer_pointer_t sel_idx;
  logic            sel_hit;
  logic            accept;
  result_t         out_reg;
  logic            out_valid_reg;

  assign in_ready = rst_n & ~cfg_we & ~flush & (~out_valid_reg | out_ready);
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < BUFFER_DEPTH; gi++) begin : g_bucket
      data_t            lo_reg;
      data_t            hi_reg;
      logic [CNT_W-1:0] count_reg;
      logic             inc;
      logic             dec;

      // Bounds reset to an empty interval so every bucket starts disabled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lo_reg <= '1;
          hi_reg <= '0;
        end else if (cfg_we && (cfg_idx == buffer_pointer_t'(gi))) begin
          lo_reg <= cfg_lo;
          hi_reg <= cfg_hi;
        end
      end

      // Accept reserves a slot at once; a drain on an empty bucket is dropped.
      assign inc = accept & sel_hit & (sel_idx == buffer_pointer_t'(gi));
      assign dec = drain_valid & (drain_idx == buffer_pointer_t'(gi)) & (count_reg != '0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_reg <= '0;
        end else if (flush) begin
          count_reg <= '0;
        end else if (inc && !dec) begin
          count_reg <= count_reg + CNT_W'(1);
        end else if (dec && !inc) begin
          count_reg <= count_reg - CNT_W'(1);
        end
      end

      assign lo_arr[gi]  = lo_reg;
      assign hi_arr[gi]  = hi_reg;
      assign enabled[gi] = range_enabled(lo_reg, hi_reg);
      assign full[gi]    = (count_reg == CAP_C);
    end
  endgenerate

  range_compare u_range_compare (
    .key     (in_data),
    .lo      (lo_arr),
    .hi      (hi_arr),
    .enabled (enabled),
    .full    (full),
    .fall_in (fall_in)
  );

  // Descending scan so the lowest set bit is the one left standing.
  always_comb begin
    sel_idx = '0;
    sel_hit = 1'b0;
    for (int j = BUFFER_DEPTH - 1; j >= 0; j--) begin
      if (fall_in[j]) begin
        sel_idx = buffer_pointer_t'(j);
        sel_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_reg.data  <= in_data;
      out_reg.index <= sel_hit ? sel_idx : '0;
      out_reg.miss  <= ~sel_hit;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_data    = out_reg.data;
  assign out_index   = out_reg.index;
  assign out_miss    = out_reg.miss;
  assign bucket_full = full;

endmodule

// File: tb/tb_fall_in_dispatch.sv
// Scoreboard bench for fall_in_dispatch: each accepted key queues its expected
// result; the monitor pops and compares whenever an output is consumed.
module tb_fall_in_dispatch;
  import conf_pkg::*;

  localparam int LAST = BUFFER_DEPTH - 1;

  logic                    clk;
  logic                    rst_n;
  logic                    cfg_we;
  buffer_pointer_t         cfg_idx;
  data_t                   cfg_lo;
  data_t                   cfg_hi;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  data_t                   in_data;
  logic                    out_valid;
  logic                    out_ready;
  data_t                   out_data;
  buffer_pointer_t         out_index;
  logic                    out_miss;
  logic                    drain_valid;
  buffer_pointer_t         drain_idx;
  logic [BUFFER_DEPTH-1:0] bucket_full;

  typedef struct {
    data_t           data;
    buffer_pointer_t index;
    logic            miss;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  fall_in_dispatch #(.CAP(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_lo      (cfg_lo),
    .cfg_hi      (cfg_hi),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_miss    (out_miss),
    .drain_valid (drain_valid),
    .drain_idx   (drain_idx),
    .bucket_full (bucket_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An output is consumed at the next rising edge when valid & ready mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_extra got data=%0d idx=%0d miss=%b required no output",
                 out_data, out_index, out_miss);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_data !== e.data || out_index !== e.index || out_miss !== e.miss) begin
          fails++;
          $display("FAIL scoreboard got data=%0d idx=%0d miss=%b required data=%0d idx=%0d miss=%b",
                   out_data, out_index, out_miss, e.data, e.index, e.miss);
        end else begin
          $display("out data=%0d idx=%0d miss=%b", out_data, out_index, out_miss);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic send(input data_t key, input int exp_idx, input bit exp_miss, output int waits);
    exp_t e;
    waits    = 0;
    in_valid = 1'b1;
    in_data  = key;
    @(negedge clk);
    while (!in_ready && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_timeout key=%0d in_ready=%b required 1", key, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.data  = key;
    e.index = buffer_pointer_t'(exp_idx);
    e.miss  = exp_miss;
    exp_q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic send1(input data_t key, input int exp_idx, input bit exp_miss);
    int w;
    send(key, exp_idx, exp_miss, w);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_timeout pending=%0d out_valid=%b required 0 and 0", exp_q.size(), out_valid);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input data_t lo, input data_t hi);
    cfg_we  = 1'b1;
    cfg_idx = buffer_pointer_t'(idx);
    cfg_lo  = lo;
    cfg_hi  = hi;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL cfg_blocks_input in_ready=%b required 0", in_ready);
    end
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic do_drain(input int idx);
    drain_valid = 1'b1;
    drain_idx   = buffer_pointer_t'(idx);
    @(posedge clk);
    #1 drain_valid = 1'b0;
  endtask

  task automatic check_full(input string name, input logic [BUFFER_DEPTH-1:0] expv);
    checks++;
    if (bucket_full !== expv) begin
      fails++;
      $display("FAIL %s bucket_full=%b required %b", name, bucket_full, expv);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_index !== '0 || out_miss !== 1'b0 ||
        in_ready !== 1'b0 || bucket_full !== '0) begin
      fails++;
      $display("FAIL reset_state valid=%b data=%0d idx=%0d miss=%b ready=%b full=%b required all 0",
               out_valid, out_data, out_index, out_miss, in_ready, bucket_full);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    send1(16'd0, 0, 1'b1);
    wait_idle();
  endtask

  task automatic test_ranges();
    cfg(0, 16'd0, 16'd9);
    cfg(1, 16'd10, 16'd19);
    cfg(2, 16'd5, 16'd15);
    send1(16'd7, 0, 1'b0);
    send1(16'd12, 1, 1'b0);
    send1(16'd30, 0, 1'b1);
    wait_idle();
    do_flush();
  endtask

  task automatic test_last_bucket();
    for (int i = 0; i < LAST; i++) cfg(i, 16'hFFFF, 16'd0);
    cfg(LAST, 16'd100, 16'd200);
    send1(16'd150, LAST, 1'b0);
    send1(16'd99, 0, 1'b1);
    send1(16'd200, LAST, 1'b0);
    wait_idle();
    checks++;
    if (bucket_full[LAST] !== 1'b1) begin
      fails++;
      $display("FAIL last_bucket_full got %b required 1", bucket_full[LAST]);
    end
    do_flush();
    cfg(LAST, 16'hFFFF, 16'd0);
  endtask

  task automatic test_capacity();
    cfg(0, 16'd0, 16'd9);
    cfg(2, 16'd5, 16'd15);
    send1(16'd6, 0, 1'b0);
    send1(16'd6, 0, 1'b0);
    check_full("cap_after_two", BUFFER_DEPTH'(1));
    send1(16'd6, 2, 1'b0);
    wait_idle();
    check_full("cap_after_three", BUFFER_DEPTH'(1));
    do_drain(0);
    check_full("cap_after_drain", '0);
    send1(16'd6, 0, 1'b0);
    wait_idle();
    check_full("cap_refill", BUFFER_DEPTH'(1));
    do_flush();
    check_full("cap_flushed", '0);
  endtask

  task automatic test_counter_corner();
    exp_t e;
    send1(16'd6, 0, 1'b0);
    in_valid    = 1'b1;
    in_data     = 16'd6;
    drain_valid = 1'b1;
    drain_idx   = '0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL inc_drain_ready in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    e.data  = 16'd6;
    e.index = '0;
    e.miss  = 1'b0;
    exp_q.push_back(e);
    #1;
    in_valid    = 1'b0;
    drain_valid = 1'b0;
    check_full("inc_drain_same_cycle", '0);
    send1(16'd6, 0, 1'b0);
    check_full("inc_drain_then_one", BUFFER_DEPTH'(1));
    send1(16'd6, 2, 1'b0);
    wait_idle();
    do_flush();
    do_drain(0);
    send1(16'd6, 0, 1'b0);
    send1(16'd6, 0, 1'b0);
    check_full("drain_empty_saturates", BUFFER_DEPTH'(1));
    send1(16'd6, 2, 1'b0);
    wait_idle();
    do_flush();
  endtask

  task automatic test_back_to_back();
    int w;
    out_ready = 1'b0;
    send1(16'd40, 0, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'd41;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'd40 || out_miss !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold cycle=%0d ready=%b valid=%b data=%0d miss=%b required 0 1 40 1",
                 c, in_ready, out_valid, out_data, out_miss);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int k = 41; k <= 44; k++) begin
      send(data_t'(k), 0, 1'b1, w);
      checks++;
      if (w != 0) begin
        fails++;
        $display("FAIL no_bubble key=%0d wait_cycles=%0d required 0", k, w);
      end
    end
    wait_idle();
  endtask

  task automatic test_flush();
    send1(16'd6, 0, 1'b0);
    wait_idle();
    out_ready = 1'b0;
    send1(16'd6, 0, 1'b0);
    check_full("flush_pre_full", BUFFER_DEPTH'(1));
    do_flush();
    checks++;
    if (out_valid !== 1'b0 || bucket_full !== '0) begin
      fails++;
      $display("FAIL flush_clears out_valid=%b full=%b required 0 0", out_valid, bucket_full);
    end
    out_ready = 1'b1;
    send1(16'd6, 0, 1'b0);
    send1(16'd6, 0, 1'b0);
    send1(16'd6, 2, 1'b0);
    wait_idle();
    do_flush();
  endtask

  task automatic test_async_reset();
    send1(16'd6, 0, 1'b0);
    wait_idle();
    out_ready = 1'b0;
    send1(16'd6, 0, 1'b0);
    check_full("rst_pre_full", BUFFER_DEPTH'(1));
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_index !== '0 || out_miss !== 1'b0 ||
        in_ready !== 1'b0 || bucket_full !== '0) begin
      fails++;
      $display("FAIL async_reset valid=%b data=%0d idx=%0d miss=%b ready=%b full=%b required all 0",
               out_valid, out_data, out_index, out_miss, in_ready, bucket_full);
    end
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send1(16'd6, 0, 1'b1);
    wait_idle();
  endtask

  initial begin
    rst_n       = 1'b0;
    cfg_we      = 1'b0;
    cfg_idx     = '0;
    cfg_lo      = '0;
    cfg_hi      = '0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    drain_valid = 1'b0;
    drain_idx   = '0;

    test_reset();
    test_ranges();
    test_last_bucket();
    test_capacity();
    test_counter_corner();
    test_back_to_back();
    test_flush();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
